// File: rtl/pipe_stop_pkg.sv
// Shared types and defaults for the pipeline stop requester.
package pipe_stop_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ASSERT     = 3'd1,
    WAIT_DRAIN = 3'd2,
    HALTED     = 3'd3,
    REFILL     = 3'd4
  } state_e;

  localparam int unsigned REQ_PULSE_DEF     = 2;
  localparam int unsigned DRAIN_TIMEOUT_DEF = 64;
  localparam int unsigned REFILL_CYCLES_DEF = 15;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/stop_down_counter.sv
// Loadable down-counter that holds at zero; reports zero combinationally.
module stop_down_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clock,
  input  logic             n_reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clock) begin
    if (!n_reset) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/pipe_stop_requester.sv
// Initiator side of the pipeline stop handshake: halt/resume requests to stop pulse and clock enables.
// STOP_TIMEOUT_EN enables the forced halt after DRAIN_TIMEOUT cycles and the sticky timeout_err flag.
module pipe_stop_requester
  import pipe_stop_pkg::*;
#(
  parameter int unsigned REQ_PULSE     = REQ_PULSE_DEF,
  parameter int unsigned DRAIN_TIMEOUT = DRAIN_TIMEOUT_DEF,
  parameter int unsigned REFILL_CYCLES = REFILL_CYCLES_DEF
) (
  input  logic clock,
  input  logic n_reset,
  input  logic halt_req,
  input  logic resume_req,
  input  logic stop,
  output logic n_stop_request,
  output logic accept_en,
  output logic pipe_enable,
  output logic halted,
  output logic busy,
  output logic timeout_err
);

`ifdef STOP_TIMEOUT_EN
  localparam int unsigned CNT_MAX = max2(max2(REQ_PULSE, DRAIN_TIMEOUT), REFILL_CYCLES);
`else
  localparam int unsigned CNT_MAX = max2(REQ_PULSE, REFILL_CYCLES);
`endif
  localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);

  state_e           state_q, state_d;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_load_val;
  logic             n_stop_request_q, n_stop_request_d;
  logic             accept_en_q, accept_en_d;
  logic             pipe_enable_q, pipe_enable_d;
  logic             halted_q, halted_d;
  logic             busy_q, busy_d;

  stop_down_counter #(.WIDTH(CNT_W)) u_cnt (
    .clock      (clock),
    .n_reset    (n_reset),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

`ifdef STOP_TIMEOUT_EN
  logic timeout_hit;
  logic timeout_err_q, timeout_err_d;
`else
  logic unused_drain_cfg;
  assign unused_drain_cfg = ^32'(DRAIN_TIMEOUT);
`endif

  // Next state, counter control and next registered outputs
  always_comb begin
    state_d      = state_q;
    cnt_load_val = '0;
`ifdef STOP_TIMEOUT_EN
    timeout_hit  = 1'b0;
`endif
    case (state_q)
      IDLE:       if (halt_req) state_d = ASSERT;
      ASSERT:     if (cnt_zero) state_d = WAIT_DRAIN;
      WAIT_DRAIN: begin
        if (stop) begin
          state_d = HALTED;
`ifdef STOP_TIMEOUT_EN
        end else if (cnt_zero) begin
          state_d     = HALTED;
          timeout_hit = 1'b1;
`endif
        end
      end
      HALTED:     if (resume_req && !halt_req) state_d = REFILL;
      REFILL: begin
        if (halt_req)      state_d = ASSERT;
        else if (cnt_zero) state_d = IDLE;
      end
      default:    state_d = IDLE;
    endcase

    cnt_load = (state_d != state_q);
    cnt_dec  = !cnt_load;
    case (state_d)
      ASSERT:     cnt_load_val = CNT_W'(REQ_PULSE - 1);
`ifdef STOP_TIMEOUT_EN
      WAIT_DRAIN: cnt_load_val = CNT_W'(DRAIN_TIMEOUT - 1);
`endif
      REFILL:     cnt_load_val = CNT_W'(REFILL_CYCLES - 1);
      default:    cnt_load_val = '0;
    endcase

    n_stop_request_d = 1'b1;
    accept_en_d      = 1'b1;
    pipe_enable_d    = 1'b1;
    halted_d         = 1'b0;
    busy_d           = 1'b0;
    case (state_d)
      ASSERT: begin
        n_stop_request_d = 1'b0;
        accept_en_d      = 1'b0;
        busy_d           = 1'b1;
      end
      WAIT_DRAIN: begin
        accept_en_d = 1'b0;
        busy_d      = 1'b1;
      end
      HALTED: begin
        accept_en_d   = 1'b0;
        pipe_enable_d = 1'b0;
        halted_d      = 1'b1;
      end
      REFILL:  busy_d = 1'b1;
      default: ;
    endcase

`ifdef STOP_TIMEOUT_EN
    timeout_err_d = timeout_err_q;
    if ((state_d == ASSERT) && (state_q != ASSERT)) timeout_err_d = 1'b0;
    if (timeout_hit) timeout_err_d = 1'b1;
`endif
  end

  always_ff @(posedge clock) begin
    if (!n_reset) begin
      state_q          <= IDLE;
      n_stop_request_q <= 1'b1;
      accept_en_q      <= 1'b1;
      pipe_enable_q    <= 1'b1;
      halted_q         <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      n_stop_request_q <= n_stop_request_d;
      accept_en_q      <= accept_en_d;
      pipe_enable_q    <= pipe_enable_d;
      halted_q         <= halted_d;
      busy_q           <= busy_d;
    end
  end

`ifdef STOP_TIMEOUT_EN
  always_ff @(posedge clock) begin
    if (!n_reset) timeout_err_q <= 1'b0;
    else          timeout_err_q <= timeout_err_d;
  end
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign n_stop_request = n_stop_request_q;
  assign accept_en      = accept_en_q;
  assign pipe_enable    = pipe_enable_q;
  assign halted         = halted_q;
  assign busy           = busy_q;

endmodule
